// File: rtl/stage_oencode_if.sv
// ---------------------------------------------------------------------------
// stage_oencode_if
// Groups the operation-in / opcode-out handshake of the opcode encoder stage.
//
// Signals:
//   operation    8  one-hot operation from the pipeline (all-zero = bubble)
//   ack          1  stage can accept an operation this cycle
//   opcode       8  ASCII opcode byte presented to the consumer
//   opcode_valid 1  opcode holds a valid byte
//   ack_in       1  consumer takes opcode when opcode_valid is also high
//   error        1  sticky flag, set when a multi-hot operation is accepted
//   count        16 number of bytes delivered, wraps modulo 2^16
//
// Modports:
//   master  pipeline/consumer side (drives operation and ack_in)
//   slave   the encoder stage itself
// ---------------------------------------------------------------------------
interface stage_oencode_if;
    logic [7:0]  operation;
    logic        ack;
    logic [7:0]  opcode;
    logic        opcode_valid;
    logic        ack_in;
    logic        error;
    logic [15:0] count;

    modport master (
        output operation,
        output ack_in,
        input  ack,
        input  opcode,
        input  opcode_valid,
        input  error,
        input  count
    );

    modport slave (
        input  operation,
        input  ack_in,
        output ack,
        output opcode,
        output opcode_valid,
        output error,
        output count
    );
endinterface

// File: rtl/stage_oencode.sv
// ---------------------------------------------------------------------------
// stage_oencode
// Translates one-hot pipeline operations into ASCII opcode bytes and queues
// them in a small FIFO for a downstream consumer with a valid/ack handshake.
// Multi-hot operations are queued as '?' and raise a sticky error flag.
//
// Parameters:
//   DEPTH  number of queued bytes (power of two, 2..16)
//
// Ports:
//   clk    sole clock, rising edge
//   reset  asynchronous, active-low; clears all state immediately
//   bus    stage_oencode_if.slave (operation/ack in, opcode/valid/ack_in out,
//          error and delivered-byte count)
// ---------------------------------------------------------------------------
module stage_oencode #(
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    stage_oencode_if.slave  bus
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_next;
    logic [OCC_W-1:0] occ;
    logic [OCC_W-1:0] occ_next;
    logic             push;
    logic             pop;
    logic             multi_hot;
    logic [7:0]       enc_byte;
    logic [7:0]       head_next;

    // Occupancy includes the entry currently shown on opcode, so a full
    // queue refuses a push even when the consumer pops on the same edge.
    assign bus.ack = (occ < FULL_OCC);
    assign push    = bus.ack && (bus.operation != 8'h00);
    assign pop     = bus.opcode_valid && bus.ack_in;

    // x & (x-1) is non-zero exactly when two or more bits are set.
    assign multi_hot = ((bus.operation & (bus.operation - 8'd1)) != 8'h00);

    always_comb begin
        enc_byte = 8'h3F;
        case (bus.operation)
            8'h01:   enc_byte = 8'h3E;
            8'h02:   enc_byte = 8'h3C;
            8'h04:   enc_byte = 8'h2B;
            8'h08:   enc_byte = 8'h2D;
            8'h10:   enc_byte = 8'h2E;
            8'h20:   enc_byte = 8'h2C;
            8'h40:   enc_byte = 8'h5B;
            8'h80:   enc_byte = 8'h5D;
            default: enc_byte = 8'h3F;
        endcase
    end

    // Next head of queue. When the write slot coincides with the new read
    // slot the queue is (becoming) empty, so the byte being pushed is the
    // new head and must bypass the not-yet-written memory.
    always_comb begin
        rd_ptr_next = pop ? (rd_ptr + PTR_W'(1)) : rd_ptr;
        occ_next    = occ;
        case ({push, pop})
            2'b10:   occ_next = occ + OCC_W'(1);
            2'b01:   occ_next = occ - OCC_W'(1);
            default: occ_next = occ;
        endcase
        if (push && (wr_ptr == rd_ptr_next)) begin
            head_next = enc_byte;
        end else begin
            head_next = mem[rd_ptr_next];
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= enc_byte;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            occ              <= '0;
            bus.opcode       <= 8'h00;
            bus.opcode_valid <= 1'b0;
            bus.error        <= 1'b0;
            bus.count        <= 16'h0000;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr           <= rd_ptr_next;
            occ              <= occ_next;
            bus.opcode_valid <= (occ_next != '0);
            bus.opcode       <= (occ_next != '0) ? head_next : 8'h00;
            if (push && multi_hot) begin
                bus.error <= 1'b1;
            end
            if (pop) begin
                bus.count <= bus.count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_stage_oencode.sv
// ---------------------------------------------------------------------------
// tb_stage_oencode
// Self-checking bench for stage_oencode (DEPTH = 4): a table of directed
// vectors for the steady-state encode/handshake path, followed by
// hand-written sequences for full-queue, error, bubble and mid-stream reset
// behaviour.
// ---------------------------------------------------------------------------
module tb_stage_oencode;

    logic clk;
    logic reset;
    int   assert_count;
    int   fail_count;

    stage_oencode_if bus ();

    stage_oencode #(.DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  op;
        logic        ack_in;
        logic [7:0]  exp_opcode;
        logic        exp_valid;
        logic        exp_ack;
        logic [15:0] exp_count;
    } vec_t;

    vec_t vecs [12];

    task automatic checkOutput(input string name, input logic [15:0] act,
                               input logic [15:0] exp);
        assert_count++;
        if (act !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive inputs, let one rising edge pass, sample 1ns later.
    task automatic applyStimulus(input logic [7:0] op, input logic ack_in);
        bus.operation = op;
        bus.ack_in    = ack_in;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        bus.operation = 8'h00;
        bus.ack_in    = 1'b0;
        reset         = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        assert_count = 0;
        fail_count   = 0;
        reset        = 1'b1;
        bus.operation = 8'h00;
        bus.ack_in    = 1'b0;

        //  op     ack_in opcode valid ack  count
        vecs[0]  = '{8'h01, 1'b1, 8'h3E, 1'b1, 1'b1, 16'd0};
        vecs[1]  = '{8'h04, 1'b1, 8'h2B, 1'b1, 1'b1, 16'd1};
        vecs[2]  = '{8'h80, 1'b1, 8'h5D, 1'b1, 1'b1, 16'd2};
        vecs[3]  = '{8'h00, 1'b1, 8'h00, 1'b0, 1'b1, 16'd3};
        vecs[4]  = '{8'h02, 1'b0, 8'h3C, 1'b1, 1'b1, 16'd3};
        vecs[5]  = '{8'h08, 1'b0, 8'h3C, 1'b1, 1'b1, 16'd3};
        vecs[6]  = '{8'h10, 1'b1, 8'h2D, 1'b1, 1'b1, 16'd4};
        vecs[7]  = '{8'h20, 1'b1, 8'h2E, 1'b1, 1'b1, 16'd5};
        vecs[8]  = '{8'h40, 1'b1, 8'h2C, 1'b1, 1'b1, 16'd6};
        vecs[9]  = '{8'h00, 1'b1, 8'h5B, 1'b1, 1'b1, 16'd7};
        vecs[10] = '{8'h00, 1'b1, 8'h00, 1'b0, 1'b1, 16'd8};
        vecs[11] = '{8'h00, 1'b1, 8'h00, 1'b0, 1'b1, 16'd8};

        // Reset state
        doReset();
        checkOutput("reset_opcode", {8'h00, bus.opcode}, 16'h0000);
        checkOutput("reset_valid", {15'd0, bus.opcode_valid}, 16'd0);
        checkOutput("reset_ack", {15'd0, bus.ack}, 16'd1);
        checkOutput("reset_error", {15'd0, bus.error}, 16'd0);
        checkOutput("reset_count", bus.count, 16'd0);

        // Table-driven encode/stream vectors
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].op, vecs[i].ack_in);
            checkOutput($sformatf("vec%0d_opcode", i), {8'h00, bus.opcode},
                        {8'h00, vecs[i].exp_opcode});
            checkOutput($sformatf("vec%0d_valid", i), {15'd0, bus.opcode_valid},
                        {15'd0, vecs[i].exp_valid});
            checkOutput($sformatf("vec%0d_ack", i), {15'd0, bus.ack},
                        {15'd0, vecs[i].exp_ack});
            checkOutput($sformatf("vec%0d_count", i), bus.count, vecs[i].exp_count);
        end
        checkOutput("table_error", {15'd0, bus.error}, 16'd0);

        // Fill to capacity with consumer stalled; 5th push refused
        doReset();
        applyStimulus(8'h01, 1'b0);
        applyStimulus(8'h02, 1'b0);
        applyStimulus(8'h04, 1'b0);
        checkOutput("fill3_ack", {15'd0, bus.ack}, 16'd1);
        applyStimulus(8'h08, 1'b0);
        checkOutput("full_ack", {15'd0, bus.ack}, 16'd0);
        checkOutput("full_opcode", {8'h00, bus.opcode}, 16'h003E);
        applyStimulus(8'h10, 1'b0);
        checkOutput("full5_ack", {15'd0, bus.ack}, 16'd0);
        checkOutput("full5_opcode_held", {8'h00, bus.opcode}, 16'h003E);
        checkOutput("full5_count", bus.count, 16'd0);

        // Full with push and pop on the same edge: push refused, one pop
        applyStimulus(8'h20, 1'b1);
        checkOutput("fullpop_ack", {15'd0, bus.ack}, 16'd1);
        checkOutput("fullpop_opcode", {8'h00, bus.opcode}, 16'h003C);
        checkOutput("fullpop_count", bus.count, 16'd1);
        applyStimulus(8'h00, 1'b1);
        checkOutput("drain1_opcode", {8'h00, bus.opcode}, 16'h002B);
        applyStimulus(8'h00, 1'b1);
        checkOutput("drain2_opcode", {8'h00, bus.opcode}, 16'h002D);
        applyStimulus(8'h00, 1'b1);
        checkOutput("drain3_valid", {15'd0, bus.opcode_valid}, 16'd0);
        checkOutput("drain3_count", bus.count, 16'd4);

        // Multi-hot operation sets sticky error
        doReset();
        applyStimulus(8'h41, 1'b1);
        checkOutput("multi_opcode", {8'h00, bus.opcode}, 16'h003F);
        checkOutput("multi_valid", {15'd0, bus.opcode_valid}, 16'd1);
        checkOutput("multi_error", {15'd0, bus.error}, 16'd1);
        applyStimulus(8'h02, 1'b1);
        checkOutput("after_multi_opcode", {8'h00, bus.opcode}, 16'h003C);
        checkOutput("after_multi_error", {15'd0, bus.error}, 16'd1);
        applyStimulus(8'h00, 1'b1);
        checkOutput("after_multi_count", bus.count, 16'd2);
        checkOutput("sticky_error", {15'd0, bus.error}, 16'd1);

        // Ten bubble cycles: nothing queued, ack_in ignored
        doReset();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(8'h00, i[0]);
            checkOutput($sformatf("bubble%0d_valid", i), {15'd0, bus.opcode_valid}, 16'd0);
        end
        checkOutput("bubble_count", bus.count, 16'd0);

        // Mid-stream asynchronous reset with three queued bytes
        doReset();
        applyStimulus(8'h01, 1'b1);
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'h41, 1'b0);
        applyStimulus(8'h02, 1'b0);
        applyStimulus(8'h04, 1'b0);
        bus.operation = 8'h00;
        checkOutput("pre_rst_valid", {15'd0, bus.opcode_valid}, 16'd1);
        checkOutput("pre_rst_error", {15'd0, bus.error}, 16'd1);
        checkOutput("pre_rst_count", bus.count, 16'd1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async_rst_opcode", {8'h00, bus.opcode}, 16'h0000);
        checkOutput("async_rst_valid", {15'd0, bus.opcode_valid}, 16'd0);
        checkOutput("async_rst_error", {15'd0, bus.error}, 16'd0);
        checkOutput("async_rst_count", bus.count, 16'd0);
        checkOutput("async_rst_ack", {15'd0, bus.ack}, 16'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        applyStimulus(8'h08, 1'b1);
        checkOutput("post_rst_first", {8'h00, bus.opcode}, 16'h002D);
        checkOutput("post_rst_valid", {15'd0, bus.opcode_valid}, 16'd1);
        applyStimulus(8'h00, 1'b1);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("no_stale%0d_valid", i), {15'd0, bus.opcode_valid}, 16'd0);
            applyStimulus(8'h00, 1'b1);
        end
        checkOutput("post_rst_count", bus.count, 16'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/stage_oencode.md
STAGE_OENCODE -- requirements
Module: StageOEncode

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of FIFO entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset; low clears all state immediately, independent of clk.
REQ-004 SHALL have port operation  input  `OPCODE_MSB+1 (8)  one-hot operation from pipeline; all-zero = bubble.
REQ-005 SHALL have port ack  output  1  high = block can accept an operation this cycle.
REQ-006 SHALL have port opcode  output  8  ASCII opcode byte presented to consumer.
REQ-007 SHALL have port opcode_valid  output  1  opcode holds a valid byte.
REQ-008 SHALL have port ack_in  input  1  consumer takes opcode this cycle when opcode_valid is also high.
REQ-009 SHALL have port error  output  1  sticky flag, set on a multi-hot operation.
REQ-010 SHALL have port count  output  16  number of bytes delivered to the consumer, wraps modulo 2^16.

Function
REQ-011 SHALL drive ack high exactly when FIFO occupancy < DEPTH; no same-cycle bypass when full (ack low even if a pop also occurs).
REQ-012 SHALL push on a rising edge when ack is high and operation is non-zero; all-zero operation SHALL never push.
REQ-013 SHALL encode: bit0->8'h3E, bit1->8'h3C, bit2->8'h2B, bit3->8'h2D, bit4->8'h2E, bit5->8'h2C, bit6->8'h5B, bit7->8'h5D.
REQ-014 SHALL encode any operation with two or more bits set as 8'h3F ('?'), push it as a normal entry, and set error on the same edge.
REQ-015 SHALL keep error set until reset; later valid operations SHALL NOT clear it.
REQ-016 SHALL register opcode/opcode_valid; a byte pushed into an empty FIFO at edge N SHALL appear with opcode_valid high after edge N and not before.
REQ-017 SHALL pop the head entry on an edge where opcode_valid and ack_in are both high; count SHALL increment by 1 on that edge.
REQ-018 SHALL hold opcode stable while opcode_valid is high and ack_in is low.
REQ-019 SHALL, with ack_in held high and continuous pushes, sustain one byte per cycle in FIFO order.
REQ-020 SHALL handle simultaneous push and pop with occupancy unchanged and no loss or duplication.
REQ-021 SHALL wrap read/write pointers modulo DEPTH with separate occupancy tracking so full and empty are distinguished.
REQ-022 SHALL wrap count from 16'hFFFF to 16'h0000 without side effects.
REQ-023 SHALL ignore ack_in while opcode_valid is low.

Reset
REQ-024 SHALL, while reset is low, force FIFO empty, opcode=8'h00, opcode_valid=0, error=0, count=0, ack=1.
REQ-025 SHALL discard all queued bytes on a reset asserted mid-stream; no byte from before reset is emitted afterward.
REQ-026 SHALL accept operations on the first rising edge after reset deasserts.

Verification
REQ-027 Bench SHALL cover: push 8'h01,8'h04,8'h80 with ack_in=1 -> bytes 3E,2B,5D on consecutive cycles, count=3.
REQ-028 Bench SHALL cover: ack_in=0, push 5 non-zero ops with DEPTH=4 -> ack low after 4th push, 5th not accepted, opcode held at first byte.
REQ-029 Bench SHALL cover: push 8'h41 -> byte 3F emitted, error=1 and stays 1 after subsequent push 8'h02 (byte 3C).
REQ-030 Bench SHALL cover: operation=8'h00 for 10 cycles -> opcode_valid stays 0, count unchanged.
REQ-031 Bench SHALL cover: FIFO full, ack_in=1 and push on same cycle -> push refused, one byte popped, ack high next cycle.
REQ-032 Bench SHALL cover: reset low mid-stream with 3 queued bytes -> outputs cleared immediately without clock edge, no stale byte afterward.
